// File: rtl/load_align_pkg.sv
// Shared encodings for the load/store path: access sizes, FSM states and the
// rule that decides whether an access spans two memory words.
package load_align_pkg;

  localparam int DATA_WIDTH_C = 32;

  // LoadSrcM[1:0] size field, also decoded by the store formatter
  localparam logic [1:0] SIZE_WORD    = 2'b00;
  localparam logic [1:0] SIZE_BYTE    = 2'b01;
  localparam logic [1:0] SIZE_HALF    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RD_LO = 2'd1;
  localparam state_t ST_RD_HI = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic       is_unsigned;
    logic [1:0] size;
  } load_src_t;

  function automatic logic is_crossing(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SIZE_HALF) && (offset == 2'd3)) ||
           ((size == SIZE_WORD) && (offset != 2'd0));
  endfunction

endpackage

// File: rtl/load_align_unit_extend.sv
// Combinational load datapath: picks bytes out of the {hi,lo} word pair at the
// byte offset, then truncates and sign/zero-extends to the access size.
module load_extend
  import load_align_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [63:0] pair;
  logic [31:0] shifted;

  assign pair = {hi, lo};

  // Each result lane reads pair byte (lane + offset); a 4:1 byte mux per lane
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [5:0] base;
    assign base = 6'(8 * gi) + {1'b0, offset, 3'b000};
    assign shifted[8*gi +: 8] = pair[base +: 8];
  end

  always_comb begin
    data = '0;
    case (size)
      SIZE_BYTE: data = is_unsigned ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data = is_unsigned ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      SIZE_WORD: data = shifted;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: turns a byte-addressed load of byte/half/word into one
// or two word reads, then aligns and extends the result for writeback.
module load_align_unit
  import load_align_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_C
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  LoadReqM,
  output logic                  LoadReadyM,
  input  logic [2:0]            LoadSrcM,
  input  logic [DATA_WIDTH-1:0] AddrM,
  output logic                  MemReq,
  output logic [DATA_WIDTH-1:0] MemAddr,
  input  logic                  MemAck,
  input  logic [DATA_WIDTH-1:0] MemRData,
  output logic [DATA_WIDTH-1:0] ReadPartDataW,
  output logic                  LoadValidW,
  output logic                  LoadFaultW,
  output logic                  StallM
);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   addr_reg, addr_next;
  load_src_t               src_reg, src_next;
  logic [DATA_WIDTH-1:0]   lo_reg, lo_next;
  logic [DATA_WIDTH-1:0]   hi_reg, hi_next;
  logic                    fault_reg, fault_next;

  logic [DATA_WIDTH-1:0]   lo_addr;
  logic [DATA_WIDTH-1:0]   hi_addr;
  logic [DATA_WIDTH-1:0]   extended;

  assign lo_addr = {addr_reg[DATA_WIDTH-1:2], 2'b00};
  // Wraps modulo 2^DATA_WIDTH for a word straddling the top of memory
  assign hi_addr = lo_addr + DATA_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      src_reg   <= '0;
      lo_reg    <= '0;
      hi_reg    <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      src_reg   <= src_next;
      lo_reg    <= lo_next;
      hi_reg    <= hi_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    src_next   = src_reg;
    lo_next    = lo_reg;
    hi_next    = hi_reg;
    fault_next = fault_reg;
    case (state_reg)
      ST_IDLE: begin
        if (LoadReqM) begin
          addr_next = AddrM;
          src_next  = load_src_t'(LoadSrcM);
          hi_next   = '0;
          if (LoadSrcM[1:0] == SIZE_ILLEGAL) begin
            fault_next = 1'b1;
            state_next = ST_DONE;
          end else begin
            fault_next = 1'b0;
            state_next = ST_RD_LO;
          end
        end
      end
      ST_RD_LO: begin
        if (MemAck) begin
          lo_next    = MemRData;
          state_next = is_crossing(src_reg.size, addr_reg[1:0]) ? ST_RD_HI : ST_DONE;
        end
      end
      ST_RD_HI: begin
        if (MemAck) begin
          hi_next    = MemRData;
          state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  load_extend u_extend (
    .lo          (lo_reg),
    .hi          (hi_reg),
    .offset      (addr_reg[1:0]),
    .size        (src_reg.size),
    .is_unsigned (src_reg.is_unsigned),
    .data        (extended)
  );

  always_comb begin
    MemReq  = 1'b0;
    MemAddr = '0;
    case (state_reg)
      ST_RD_LO: begin
        MemReq  = 1'b1;
        MemAddr = lo_addr;
      end
      ST_RD_HI: begin
        MemReq  = 1'b1;
        MemAddr = hi_addr;
      end
      default: begin
        MemReq  = 1'b0;
        MemAddr = '0;
      end
    endcase
  end

  // Result outputs are forced quiet outside the single DONE cycle
  assign LoadValidW    = (state_reg == ST_DONE);
  assign LoadFaultW    = LoadValidW && fault_reg;
  assign ReadPartDataW = (LoadValidW && !fault_reg) ? extended : '0;

  assign LoadReadyM = (state_reg == ST_IDLE);
  assign StallM     = !LoadReadyM;

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the data and byte-address width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port LoadReqM, input, 1, load request valid.
REQ-005 SHALL have port LoadReadyM, output, 1, unit idle and able to accept a request.
REQ-006 SHALL have port LoadSrcM, input, 3: bit2 = unsigned; bits1:0 = size, 00 word, 01 byte, 10 half, 11 illegal.
REQ-007 SHALL have port AddrM, input, DATA_WIDTH, byte address of the load.
REQ-008 SHALL have port MemReq, output, 1, memory word-read request.
REQ-009 SHALL have port MemAddr, output, DATA_WIDTH, word-aligned read address, with bits 1:0 equal to 0.
REQ-010 SHALL have port MemAck, input, 1, read data valid this cycle.
REQ-011 SHALL have port MemRData, input, DATA_WIDTH, read word.
REQ-012 SHALL have port ReadPartDataW, output, DATA_WIDTH, aligned and extended load result.
REQ-013 SHALL have port LoadValidW, output, 1, one-cycle result strobe.
REQ-014 SHALL have port LoadFaultW, output, 1, illegal-size flag, qualified by LoadValidW.
REQ-015 SHALL have port StallM, output, 1, equal to the inverse of LoadReadyM.

Function
REQ-016 SHALL implement FSM states IDLE, RD_LO, RD_HI, DONE; LoadReadyM SHALL be 1 only in IDLE.
REQ-017 SHALL accept a request when LoadReqM and LoadReadyM are both 1, latching AddrM and LoadSrcM; LoadReqM SHALL be ignored in all other states.
REQ-018 On acceptance, SHALL move to RD_LO, or to DONE with the fault set if size is 11; an illegal size SHALL issue no memory read.
REQ-019 In RD_LO, SHALL drive MemReq=1 with MemAddr={addr[31:2],2'b00} and hold both until MemAck=1, then capture MemRData as lo.
REQ-020 SHALL treat an access as crossing when it is a half with offset 3, or a word with offset not equal to 0; a byte access never crosses.
REQ-021 After the lo capture, a crossing access SHALL go to RD_HI, which reads MemAddr = lo address + 4 (modulo 2^32) with the same hold-until-ack rule, capturing hi; a non-crossing access SHALL go to DONE.
REQ-022 MemAck SHALL be ignored while MemReq=0.
REQ-023 In DONE, SHALL drive LoadValidW=1 for exactly one cycle, then return to IDLE.
REQ-024 The result SHALL be formed as ({hi,lo} >> 8*offset), truncated to the access size.
REQ-025 The result SHALL be sign-extended when bit2=0 and zero-extended when bit2=1; a word load ignores bit2.
REQ-026 A fault result SHALL be ReadPartDataW=0 with LoadFaultW=1.
REQ-027 Latency from the acceptance edge to LoadValidW SHALL be:
- aligned access, zero-wait memory: 2 cycles;
- crossing access, zero-wait memory: 3 cycles;
- illegal size: 1 cycle;
- plus 1 cycle per wait cycle.
REQ-028 ReadPartDataW and LoadFaultW SHALL be 0 whenever LoadValidW=0.

Reset
REQ-029 reset=0 at a rising edge SHALL force IDLE from any state, including mid-read.
REQ-030 Under reset, outputs SHALL be:
- LoadReadyM=1 and StallM=0;
- MemReq=0 and MemAddr=0;
- LoadValidW=0, LoadFaultW=0 and ReadPartDataW=0.
REQ-031 An aborted load SHALL produce no LoadValidW.

Structure
REQ-032 The size encodings and the FSM state enum SHALL live in the shared package and be reused by the store formatter.
REQ-033 The shift and extend datapath SHALL be one combinational sub-module, load_extend; the FSM and registers SHALL stay in load_align_unit.

Verification
REQ-034 LB and LBU at 0x1002, with word 0x1000 = 0x12803456, SHALL give 0xFFFFFF80 and 0x00000080 respectively, each with one read and valid 2 cycles after accept.
REQ-035 LH at 0x2003, with 0x2000 = 0xAABBCCDD and 0x2004 = 0x11223344, SHALL read 0x2000 then 0x2004 and give 0x000044AA, valid 3 cycles after accept.
REQ-036 LW at 0x3000 with MemAck delayed 2 cycles SHALL hold MemReq and MemAddr stable, give valid 4 cycles after accept, and ignore LoadReqM while busy.
REQ-037 LoadSrcM=011 SHALL produce no MemReq, with LoadValidW=1, LoadFaultW=1 and data 0 one cycle after accept.
REQ-038 LW at 0xFFFFFFFE SHALL read 0xFFFFFFFC then 0x00000000.
REQ-039 Asserting reset during RD_HI SHALL give MemReq=0 and LoadReadyM=1 after the edge, with no LoadValidW.
